memory_unit: RTL
================

# memory_unit

Parametrised single-port-write / single-port-read data memory for the datapath, replacing the fixed 16×16 store. Adds configurable width and depth, a registered read with a valid strobe, an automatic zero-fill sequence after reset, full-range address checking with an error strobe, and optional write-to-read bypass. It sits between the execute stage and load/store logic. Callers must honour `Busy`.

## Interface
- `DATA_W`, 16, data word width in bits.
- `ADDR_W`, 16, address port width in bits.
- `DEPTH`, 16, number of words; 1 ≤ DEPTH ≤ 2^ADDR_W; need not be a power of two.

Ports:
- `Clock` in 1: single clock; all state updates on the rising edge.
- `Reset` in 1: asynchronous, active-high reset.
- `Write_Enable` in 1: write request this cycle.
- `Write_Address` in ADDR_W: write word address.
- `Write_Data` in DATA_W: write data.
- `Read_Enable` in 1: read request this cycle.
- `Read_Address` in ADDR_W: read word address.
- `Read_Data` out DATA_W: registered read data.
- `Read_Valid` out 1: one-cycle strobe; `Read_Data` updated this cycle.
- `Busy` out 1: zero-fill in progress; requests ignored.
- `Error` out 1: one-cycle strobe; out-of-range access accepted last edge.

## Operation
- FSM states:
  - CLEAR: entered on `Reset`. Internal counter `clr_idx` writes 0 to `mem[clr_idx]` each edge and increments. On the edge that writes `mem[DEPTH-1]`, the FSM moves to IDLE.
  - IDLE: normal service. There is no other exit except `Reset`.
- Range check: an address is in range iff the full ADDR_W value < DEPTH. Every index 0..DEPTH-1 is usable.
- Write (IDLE, `Write_Enable`=1):
  - In range: `mem[Write_Address]` ← `Write_Data` at the edge.
  - Out of range: dropped, and `Error` is set for the next cycle.
- Read (IDLE, `Read_Enable`=1):
  - In range: `Read_Data` ← `mem[Read_Address]` at the edge, and `Read_Valid`=1 for the next cycle.
  - Out of range: `Read_Data` ← 0, `Read_Valid`=1, and `Error`=1 for the next cycle.
- No read accepted: `Read_Data` holds its last value and `Read_Valid`=0.
- Read and write may both be accepted on the same edge. If both are out of range, `Error` is a single one-cycle strobe.
- In CLEAR, `Write_Enable` and `Read_Enable` are ignored: no memory change, `Read_Valid` stays 0, `Error` stays 0.
- Same-address read and write on the same edge: see Configuration.

## Timing
- Reset values, applied asynchronously while `Reset`=1:
  - `Read_Data`=0, `Read_Valid`=0, `Error`=0, `Busy`=1.
  - FSM=CLEAR, `clr_idx`=0.
  - Memory contents are not reset directly; the zero-fill sequence clears them.
- Zero-fill timing: edges 1..DEPTH after `Reset` falls write addresses 0..DEPTH-1. `Busy` drops after edge DEPTH. The first request is accepted on edge DEPTH+1.
- `Reset` reasserted mid-fill or mid-operation: immediate return to the reset values, and the fill restarts from address 0.
- Read latency: 1 cycle from the request edge. A new read can be accepted every cycle.
- Write latency: data is visible to a read accepted on the following edge.
- `Error` and `Read_Valid` are never held beyond one cycle unless a new triggering request arrives.

## Configuration
- `MEM_BYPASS_EN` defined (write-first): same-edge, same in-range address read returns `Write_Data`.
- `MEM_BYPASS_EN` undefined (read-first): the same read returns the old `mem` contents.
- All other behaviour is identical in both builds.

## Test plan
- Reset pulse, then wait: `Busy`=1 for exactly 16 edges after `Reset` falls, then 0. Reading addresses 0..15 returns 0 with `Read_Valid` strobes.
- Write 0xBEEF to address 15, read address 15 next cycle: `Read_Data`=0xBEEF, `Read_Valid`=1 one cycle after the read edge, `Error`=0.
- Write 0x1234 to address 16, and read address 0xFFFF: each gives a one-cycle `Error`=1. The read returns 0. `mem` is unchanged.
- Address 3 holds 0x00AA; write 0x5555 and read address 3 on the same edge:
  - With `MEM_BYPASS_EN`: `Read_Data`=0x5555.
  - Without: `Read_Data`=0x00AA.
- Issue writes and reads while `Busy`=1: no `Read_Valid`, no `Error`, and memory reads back as 0 after the fill.
- Assert `Reset` at fill address 7: outputs return to reset values immediately, and `Busy` lasts a fresh 16 cycles.

Source files
------------

// File: rtl/memory_unit.sv
// rtl/memory_unit.sv - parametrised data memory with zero-fill, registered read, range check
// Optional write-first same-address bypass when MEM_BYPASS_EN is defined (read-first otherwise).
module memory_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Write_Enable,
  input  logic [ADDR_W-1:0] Write_Address,
  input  logic [DATA_W-1:0] Write_Data,
  input  logic              Read_Enable,
  input  logic [ADDR_W-1:0] Read_Address,
  output logic [DATA_W-1:0] Read_Data,
  output logic              Read_Valid,
  output logic              Busy,
  output logic              Error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              idle;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_ok;
  logic              wr_bad;
  logic              rd_req;
  logic              rd_bad;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_word;

  assign idle        = (state == ST_IDLE);
  assign Busy        = (state == ST_CLEAR);
  // Full-width compare so aliased high address bits are caught as out of range.
  assign wr_in_range = ({1'b0, Write_Address} < DEPTH_L);
  assign rd_in_range = ({1'b0, Read_Address} < DEPTH_L);
  assign wr_idx      = Write_Address[IDX_W-1:0];
  assign rd_idx      = Read_Address[IDX_W-1:0];
  assign wr_ok       = idle && Write_Enable && wr_in_range;
  assign wr_bad      = idle && Write_Enable && !wr_in_range;
  assign rd_req      = idle && Read_Enable;
  assign rd_bad      = rd_req && !rd_in_range;

  always_comb begin
    rd_word = mem[rd_idx];
`ifdef MEM_BYPASS_EN
    if (wr_ok && (wr_idx == rd_idx)) begin
      rd_word = Write_Data;
    end
`endif
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= ST_CLEAR;
      clr_idx    <= '0;
      Read_Data  <= '0;
      Read_Valid <= 1'b0;
      Error      <= 1'b0;
    end else begin
      Read_Valid <= 1'b0;
      Error      <= 1'b0;
      case (state)
        ST_CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state   <= ST_IDLE;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        default: begin
          Read_Valid <= rd_req;
          Error      <= wr_bad || rd_bad;
          if (rd_req) begin
            Read_Data <= rd_in_range ? rd_word : '0;
          end
        end
      endcase
    end
  end

  // Storage has no reset; the fill sequence owns the write port while busy.
  always_ff @(posedge Clock) begin
    if (Busy) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[wr_idx] <= Write_Data;
    end
  end

endmodule
